// File: rtl/aurora_tx_arbiter.sv
`timescale 1ns/1ps
// aurora_tx_arbiter
//
// Shares the single 32-bit Aurora 8B10B framing TX AXI-Stream port between
// two packet sources with packet-granular round-robin arbitration. Access is
// sequenced against the link state: no grant is issued until channel-up has
// stayed high for P_UP_WAIT user-clock cycles, and a packet interrupted by
// loss of channel-up is drained from its source and counted as dropped.
//
// Parameters
//   P_UP_WAIT       cycles channel-up must stay high before the first grant
//                   (0 = go straight to arbitration)
//
// Ports
//   i_user_clk      user clock from aurora_channel
//   i_rst           synchronous active-high reset
//   i_channel_up    channel-up, already synchronous to i_user_clk
//   s0_axi_tx_*     packet source 0 (tdata/tkeep/tlast/tvalid in, tready out)
//   s1_axi_tx_*     packet source 1 (tdata/tkeep/tlast/tvalid in, tready out)
//   m_axi_tx_*      to the s_axi_tx_* port of aurora_channel
//   o_grant         one-hot current owner (bit0 = s0), 00 when nobody owns
//   o_link_ready    high while arbitrating or transferring
//   o_drop_cnt      packets flushed due to link loss, saturating
module aurora_tx_arbiter #(
  parameter int P_UP_WAIT = 256
) (
  input  logic        i_user_clk,
  input  logic        i_rst,
  input  logic        i_channel_up,
  input  logic [0:31] s0_axi_tx_tdata,
  input  logic [0:3]  s0_axi_tx_tkeep,
  input  logic        s0_axi_tx_tlast,
  input  logic        s0_axi_tx_tvalid,
  output logic        s0_axi_tx_tready,
  input  logic [0:31] s1_axi_tx_tdata,
  input  logic [0:3]  s1_axi_tx_tkeep,
  input  logic        s1_axi_tx_tlast,
  input  logic        s1_axi_tx_tvalid,
  output logic        s1_axi_tx_tready,
  output logic [0:31] m_axi_tx_tdata,
  output logic [0:3]  m_axi_tx_tkeep,
  output logic        m_axi_tx_tlast,
  output logic        m_axi_tx_tvalid,
  input  logic        m_axi_tx_tready,
  output logic [1:0]  o_grant,
  output logic        o_link_ready,
  output logic [15:0] o_drop_cnt
);

  // A zero settle interval would give a zero-width counter, so keep one bit.
  localparam int CNT_W = (P_UP_WAIT > 0) ? $clog2(P_UP_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    (P_UP_WAIT > 0) ? CNT_W'(P_UP_WAIT - 1) : '0;

  typedef enum logic [2:0] {
    ST_DOWN,
    ST_SETTLE,
    ST_IDLE,
    ST_XFER,
    ST_FLUSH
  } state_t;

  state_t           state;
  logic [1:0]       grant;
  logic             rr_favour_s1;
  logic [CNT_W-1:0] settle_cnt;
  logic [15:0]      drop_cnt;

  logic        sel_tvalid;
  logic        sel_tlast;
  logic [0:31] sel_tdata;
  logic [0:3]  sel_tkeep;
  logic        last_accepted;

  assign o_grant      = grant;
  assign o_link_ready = (state == ST_IDLE) || (state == ST_XFER);
  assign o_drop_cnt   = drop_cnt;

  // Selected source view. Valid/last are masked by the one-hot grant so they
  // read 0 when nobody owns the port.
  always_comb begin
    sel_tvalid = (grant[0] & s0_axi_tx_tvalid) | (grant[1] & s1_axi_tx_tvalid);
    sel_tlast  = (grant[0] & s0_axi_tx_tlast)  | (grant[1] & s1_axi_tx_tlast);
    sel_tdata  = grant[1] ? s1_axi_tx_tdata : s0_axi_tx_tdata;
    sel_tkeep  = grant[1] ? s1_axi_tx_tkeep : s0_axi_tx_tkeep;
  end

  assign last_accepted = (state == ST_XFER) && sel_tvalid && sel_tlast && m_axi_tx_tready;

  // Zero-latency passthrough in XFER; in FLUSH the owner is drained with
  // tready held high while nothing reaches the link.
  always_comb begin
    m_axi_tx_tvalid  = 1'b0;
    m_axi_tx_tdata   = '0;
    m_axi_tx_tkeep   = '0;
    m_axi_tx_tlast   = 1'b0;
    s0_axi_tx_tready = 1'b0;
    s1_axi_tx_tready = 1'b0;
    case (state)
      ST_XFER: begin
        if (grant != 2'b00) begin
          m_axi_tx_tvalid  = sel_tvalid;
          m_axi_tx_tdata   = sel_tdata;
          m_axi_tx_tkeep   = sel_tkeep;
          m_axi_tx_tlast   = sel_tlast;
          s0_axi_tx_tready = grant[0] & m_axi_tx_tready;
          s1_axi_tx_tready = grant[1] & m_axi_tx_tready;
        end
      end
      ST_FLUSH: begin
        s0_axi_tx_tready = grant[0];
        s1_axi_tx_tready = grant[1];
      end
      default: ;
    endcase
  end

  // Link sequencing and arbitration. The grant is only ever set in IDLE and
  // only cleared on a tlast, so a packet is never split between owners.
  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      state        <= ST_DOWN;
      grant        <= 2'b00;
      rr_favour_s1 <= 1'b0;
      settle_cnt   <= '0;
      drop_cnt     <= '0;
    end else begin
      case (state)
        ST_DOWN: begin
          if (i_channel_up) begin
            settle_cnt <= '0;
            state      <= (P_UP_WAIT == 0) ? ST_IDLE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + CNT_W'(1);
          if (!i_channel_up) begin
            state <= ST_DOWN;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!i_channel_up) begin
            state <= ST_DOWN;
          end else if (s0_axi_tx_tvalid && s1_axi_tx_tvalid) begin
            grant <= rr_favour_s1 ? 2'b10 : 2'b01;
            state <= ST_XFER;
          end else if (s0_axi_tx_tvalid) begin
            grant <= 2'b01;
            state <= ST_XFER;
          end else if (s1_axi_tx_tvalid) begin
            grant <= 2'b10;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // A tlast accepted in the same cycle the link drops still counts
          // as a completed packet, so nothing needs flushing.
          if (last_accepted) begin
            rr_favour_s1 <= grant[0];
            grant        <= 2'b00;
            state        <= i_channel_up ? ST_IDLE : ST_DOWN;
          end else if (!i_channel_up) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (sel_tvalid && sel_tlast) begin
            if (drop_cnt != 16'hFFFF) begin
              drop_cnt <= drop_cnt + 16'd1;
            end
            grant <= 2'b00;
            state <= ST_DOWN;
          end
        end
        default: begin
          grant <= 2'b00;
          state <= ST_DOWN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
`timescale 1ns/1ps
// tb_aurora_tx_arbiter
//
// Directed bench for aurora_tx_arbiter with a 4-cycle settle interval.
// Inputs are driven on the falling edge, outputs compared 1 ns later.
module tb_aurora_tx_arbiter;

  localparam int UP_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_up = 1'b0;
  logic [0:31] s0_tdata = '0;
  logic [0:3]  s0_tkeep = '0;
  logic        s0_tlast = 1'b0;
  logic        s0_tvalid = 1'b0;
  logic        s0_tready;
  logic [0:31] s1_tdata = '0;
  logic [0:3]  s1_tkeep = '0;
  logic        s1_tlast = 1'b0;
  logic        s1_tvalid = 1'b0;
  logic        s1_tready;
  logic [0:31] m_tdata;
  logic [0:3]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [1:0]  grant;
  logic        link_ready;
  logic [15:0] drop_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  aurora_tx_arbiter #(.P_UP_WAIT(UP_WAIT)) dut (
    .i_user_clk      (clk),
    .i_rst           (rst),
    .i_channel_up    (ch_up),
    .s0_axi_tx_tdata (s0_tdata),
    .s0_axi_tx_tkeep (s0_tkeep),
    .s0_axi_tx_tlast (s0_tlast),
    .s0_axi_tx_tvalid(s0_tvalid),
    .s0_axi_tx_tready(s0_tready),
    .s1_axi_tx_tdata (s1_tdata),
    .s1_axi_tx_tkeep (s1_tkeep),
    .s1_axi_tx_tlast (s1_tlast),
    .s1_axi_tx_tvalid(s1_tvalid),
    .s1_axi_tx_tready(s1_tready),
    .m_axi_tx_tdata  (m_tdata),
    .m_axi_tx_tkeep  (m_tkeep),
    .m_axi_tx_tlast  (m_tlast),
    .m_axi_tx_tvalid (m_tvalid),
    .m_axi_tx_tready (m_tready),
    .o_grant         (grant),
    .o_link_ready    (link_ready),
    .o_drop_cnt      (drop_cnt)
  );

  // One cycle of stimulus and the outputs it must produce.
  typedef struct {
    logic        ch;
    logic        v0, l0;
    logic [31:0] d0;
    logic [3:0]  k0;
    logic        v1, l1;
    logic [31:0] d1;
    logic [3:0]  k1;
    logic        mr;
    logic        mv;
    logic [31:0] md;
    logic [3:0]  mk;
    logic        ml, r0, r1;
    logic [1:0]  g;
    logic        lr;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic ch, v0, l0, input logic [31:0] d0, input logic [3:0] k0,
                        input logic v1, l1, input logic [31:0] d1, input logic [3:0] k1,
                        input logic mr, mv, input logic [31:0] md, input logic [3:0] mk,
                        input logic ml, r0, r1, input logic [1:0] g, input logic lr);
    vec_t v;
    v.ch = ch; v.v0 = v0; v.l0 = l0; v.d0 = d0; v.k0 = k0;
    v.v1 = v1; v.l1 = l1; v.d1 = d1; v.k1 = k1; v.mr = mr;
    v.mv = mv; v.md = md; v.mk = mk; v.ml = ml; v.r0 = r0; v.r1 = r1;
    v.g = g; v.lr = lr;
    vecs.push_back(v);
  endtask

  function automatic logic [63:0] outVec();
    return {5'd0, m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready,
            grant, link_ready, drop_cnt};
  endfunction

  function automatic logic [63:0] mkExp(input logic mv, input logic [31:0] md, input logic [3:0] mk,
                                        input logic ml, r0, r1, input logic [1:0] g,
                                        input logic lr, input logic [15:0] dc);
    return {5'd0, mv, md, mk, ml, r0, r1, g, lr, dc};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    ch_up     = v.ch;
    s0_tvalid = v.v0; s0_tlast = v.l0; s0_tdata = v.d0; s0_tkeep = v.k0;
    s1_tvalid = v.v1; s1_tlast = v.l1; s1_tdata = v.d1; s1_tkeep = v.k1;
    m_tready  = v.mr;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) until the given owner is granted; returns 1 ns after a
  // falling edge when found.
  task automatic waitGrant(input logic [1:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (grant == want) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Brings the link up, grants s0, drops the link before any beat is taken
  // and drains a one-beat remainder so exactly one drop is counted.
  task automatic doFlush(input string name, input logic [15:0] exp_drop);
    bit ok;
    ch_up = 1'b1; m_tready = 1'b0;
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = 32'h0000_0F00; s0_tkeep = 4'hF;
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    waitGrant(2'b01, ok);
    checkOutput({name, "_grant"}, {63'd0, ok}, 64'd1);
    ch_up = 1'b0;
    tick();
    s0_tlast = 1'b1;
    tick();
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    #1;
    checkOutput(name, {48'd0, drop_cnt}, {48'd0, exp_drop});
  endtask

  initial begin
    bit ok;
    int cnt0, cnt1;
    logic [1:0] exp_g;
    logic hs0, hs1;

    // Round-robin, backpressure and link-drop-on-tlast, starting from XFER
    // with s0 owning the port and the pointer favouring s0.
    //     ch v0 l0 d0        k0    v1 l1 d1        k1    mr mv md        mk    ml r0 r1 g      lr
    addVec(1, 1, 0, 32'hA0, 4'hF, 1, 0, 32'hB0, 4'hF, 1, 1, 32'hA0, 4'hF, 0, 1, 0, 2'b01, 1);
    addVec(1, 1, 0, 32'hA1, 4'hF, 1, 0, 32'hB0, 4'hF, 1, 1, 32'hA1, 4'hF, 0, 1, 0, 2'b01, 1);
    addVec(1, 1, 1, 32'hA2, 4'hF, 1, 0, 32'hB0, 4'hF, 1, 1, 32'hA2, 4'hF, 1, 1, 0, 2'b01, 1);
    addVec(1, 1, 0, 32'hA3, 4'hF, 1, 0, 32'hB0, 4'hF, 1, 0, 32'h00, 4'h0, 0, 0, 0, 2'b00, 1);
    addVec(1, 1, 0, 32'hA3, 4'hF, 1, 0, 32'hB0, 4'hF, 1, 1, 32'hB0, 4'hF, 0, 0, 1, 2'b10, 1);
    addVec(1, 1, 0, 32'hA3, 4'hF, 1, 0, 32'hB1, 4'hF, 0, 1, 32'hB1, 4'hF, 0, 0, 0, 2'b10, 1);
    addVec(1, 1, 0, 32'hA3, 4'hF, 1, 0, 32'hB1, 4'hF, 1, 1, 32'hB1, 4'hF, 0, 0, 1, 2'b10, 1);
    addVec(1, 1, 0, 32'hA3, 4'hF, 1, 0, 32'hB2, 4'hF, 0, 1, 32'hB2, 4'hF, 0, 0, 0, 2'b10, 1);
    addVec(1, 1, 0, 32'hA3, 4'hF, 1, 0, 32'hB2, 4'hF, 1, 1, 32'hB2, 4'hF, 0, 0, 1, 2'b10, 1);
    addVec(1, 1, 0, 32'hA3, 4'hF, 1, 1, 32'hB3, 4'hC, 0, 1, 32'hB3, 4'hC, 1, 0, 0, 2'b10, 1);
    addVec(1, 1, 0, 32'hA3, 4'hF, 1, 1, 32'hB3, 4'hC, 1, 1, 32'hB3, 4'hC, 1, 0, 1, 2'b10, 1);
    addVec(1, 1, 1, 32'hA3, 4'hF, 1, 1, 32'hC0, 4'hF, 1, 0, 32'h00, 4'h0, 0, 0, 0, 2'b00, 1);
    addVec(1, 1, 1, 32'hA3, 4'hF, 1, 1, 32'hC0, 4'hF, 1, 1, 32'hA3, 4'hF, 1, 1, 0, 2'b01, 1);
    addVec(1, 1, 1, 32'hA4, 4'hF, 1, 1, 32'hC0, 4'hF, 1, 0, 32'h00, 4'h0, 0, 0, 0, 2'b00, 1);
    addVec(1, 1, 1, 32'hA4, 4'hF, 1, 1, 32'hC0, 4'hF, 1, 1, 32'hC0, 4'hF, 1, 0, 1, 2'b10, 1);
    addVec(1, 0, 1, 32'hA4, 4'hF, 1, 0, 32'hD0, 4'hF, 1, 0, 32'h00, 4'h0, 0, 0, 0, 2'b00, 1);
    addVec(1, 1, 1, 32'hA4, 4'hF, 1, 0, 32'hD0, 4'hF, 1, 1, 32'hD0, 4'hF, 0, 0, 1, 2'b10, 1);
    addVec(1, 1, 1, 32'hA4, 4'hF, 1, 1, 32'hD1, 4'h8, 1, 1, 32'hD1, 4'h8, 1, 0, 1, 2'b10, 1);
    addVec(1, 1, 0, 32'hE0, 4'hF, 1, 0, 32'hF0, 4'hF, 1, 0, 32'h00, 4'h0, 0, 0, 0, 2'b00, 1);
    addVec(1, 1, 0, 32'hE0, 4'hF, 1, 0, 32'hF0, 4'hF, 1, 1, 32'hE0, 4'hF, 0, 1, 0, 2'b01, 1);
    addVec(0, 1, 1, 32'hE1, 4'hF, 1, 0, 32'hF0, 4'hF, 1, 1, 32'hE1, 4'hF, 1, 1, 0, 2'b01, 1);
    addVec(0, 1, 0, 32'hE2, 4'hF, 1, 0, 32'hF0, 4'hF, 1, 0, 32'h00, 4'h0, 0, 0, 0, 2'b00, 0);

    // Reset state.
    @(negedge clk);
    tick();
    #1;
    checkOutput("reset", outVec(), mkExp(0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 16'd0));

    // Link bring-up: channel-up rises in cycle 10, s0 requests from cycle 0.
    @(negedge clk);
    rst = 1'b0;
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = 32'hA0; s0_tkeep = 4'hF;
    m_tready = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      ch_up = (c >= 10);
      #1;
      checkOutput($sformatf("bringup_c%0d", c), {62'd0, link_ready, m_tvalid},
                  {62'd0, (c >= 15), (c >= 16)});
      tick();
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), outVec(),
                  mkExp(vecs[i].mv, vecs[i].md, vecs[i].mk, vecs[i].ml, vecs[i].r0,
                        vecs[i].r1, vecs[i].g, vecs[i].lr, 16'd0));
      tick();
    end

    // Link loss mid-packet: 8-beat s0 packet, link drops while beat 2 is
    // taken, the rest is drained, channel-up returns during the drain.
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tkeep = 4'hF; s0_tdata = 32'h100;
    ch_up = 1'b1; m_tready = 1'b1;
    repeat (5) tick();
    #1;
    checkOutput("loss_idle", outVec(), mkExp(0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 1, 16'd0));
    tick();
    for (int b = 0; b < 3; b++) begin
      s0_tdata = 32'h100 + 32'(b);
      ch_up = (b != 2);
      #1;
      checkOutput($sformatf("loss_beat%0d", b), outVec(),
                  mkExp(1, 32'h100 + 32'(b), 4'hF, 0, 1, 0, 2'b01, 1, 16'd0));
      tick();
    end
    for (int b = 3; b < 8; b++) begin
      s0_tdata = 32'h100 + 32'(b);
      s0_tlast = (b == 7);
      ch_up = (b >= 5);
      #1;
      checkOutput($sformatf("flush_beat%0d", b), outVec(),
                  mkExp(0, 32'h0, 4'h0, 0, 1, 0, 2'b01, 0, 16'd0));
      tick();
    end
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    #1;
    checkOutput("loss_down", outVec(), mkExp(0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 16'd1));
    tick();

    // Saturation: preload the counter near the top, then flush twice more.
    force dut.drop_cnt = 16'hFFFE;
    #1;
    release dut.drop_cnt;
    doFlush("sat_first", 16'hFFFF);
    tick();
    doFlush("sat_hold", 16'hFFFF);
    tick();

    // Reset pulsed mid-XFER.
    ch_up = 1'b1; m_tready = 1'b1;
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = 32'h200; s0_tkeep = 4'hF;
    waitGrant(2'b01, ok);
    checkOutput("rst_grant", {63'd0, ok}, 64'd1);
    tick();
    rst = 1'b1;
    tick();
    #1;
    checkOutput("rst_mid_xfer", outVec(), mkExp(0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 16'd0));
    rst = 1'b0;

    // Continuous 3-beat packets from both sources: grants alternate with one
    // idle cycle in between, s0 first after reset.
    s1_tvalid = 1'b1; s1_tkeep = 4'hF; s1_tlast = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (link_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("rr_link_up", {63'd0, ok}, 64'd1);
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 16; k++) begin
      s0_tlast = (cnt0 == 2); s0_tdata = 32'h300 + 32'(cnt0);
      s1_tlast = (cnt1 == 2); s1_tdata = 32'h400 + 32'(cnt1);
      #1;
      case (k % 8)
        0, 4:    exp_g = 2'b00;
        1, 2, 3: exp_g = 2'b01;
        default: exp_g = 2'b10;
      endcase
      checkOutput($sformatf("rr_k%0d", k), {62'd0, grant}, {62'd0, exp_g});
      hs0 = s0_tready;
      hs1 = s1_tready;
      tick();
      if (hs0) cnt0 = (cnt0 + 1) % 3;
      if (hs1) cnt1 = (cnt1 + 1) % 3;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/aurora_tx_arbiter.md
# aurora_tx_arbiter

Shares the single 32-bit Aurora 8B10B framing TX AXI-Stream port between two requesters, with packet-granular round-robin arbitration. Sequences access against link state: no grant before channel-up plus a settle interval, and a clean flush of any packet interrupted by loss of channel-up. Sits in the user-clock domain between the two TX packet sources and the `s_axi_tx_*` port of `aurora_channel`.

## Interface
- `P_UP_WAIT`, 256: user-clock cycles channel-up must stay high before the first grant (0 = no settle).
- `i_user_clk`  in  1  clock; `o_user_clk` of `aurora_channel`.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_channel_up`  in  1  `o_channel_up` of `aurora_channel`, already synchronous to `i_user_clk`.
- `s0_axi_tx_tdata`/`s1_axi_tx_tdata`  in  [0:31]  source data.
- `s0_axi_tx_tkeep`/`s1_axi_tx_tkeep`  in  [0:3]  source byte enables.
- `s0_axi_tx_tlast`/`s1_axi_tx_tlast`  in  1  end of packet.
- `s0_axi_tx_tvalid`/`s1_axi_tx_tvalid`  in  1  source valid.
- `s0_axi_tx_tready`/`s1_axi_tx_tready`  out  1  source ready.
- `m_axi_tx_tdata`  out  [0:31]  to Aurora `s_axi_tx_tdata`.
- `m_axi_tx_tkeep`  out  [0:3]  to Aurora `s_axi_tx_tkeep`.
- `m_axi_tx_tlast`  out  1  to Aurora `s_axi_tx_tlast`.
- `m_axi_tx_tvalid`  out  1  to Aurora `s_axi_tx_tvalid`.
- `m_axi_tx_tready`  in  1  from Aurora `s_axi_tx_tready`.
- `o_grant`  out  [1:0]  one-hot owner (bit0 = s0); 00 when no owner.
- `o_link_ready`  out  1  high in IDLE/XFER.
- `o_drop_cnt`  out  [15:0]  packets flushed due to link loss; saturates at 16'hFFFF.

## Operation
- Registered FSM states: DOWN, SETTLE, IDLE, XFER, FLUSH. Grant register, RR pointer, settle counter (width clog2(P_UP_WAIT+1)), drop counter.
- DOWN: both source treadys 0, m tvalid 0. If `i_channel_up`=1: go to SETTLE (counter cleared), or to IDLE if P_UP_WAIT=0.
- SETTLE: counter increments each cycle. `i_channel_up`=0 -> DOWN. Counter reaching P_UP_WAIT-1 with channel-up high -> IDLE. SETTLE therefore lasts exactly P_UP_WAIT cycles.
- IDLE: `i_channel_up`=0 -> DOWN. Otherwise, if any source tvalid: grant the requester. If both request, grant the one the RR pointer favours. Go to XFER.
- XFER: data, keep and last muxed from the granted source. `m_axi_tx_tvalid` = granted tvalid. Granted tready = `m_axi_tx_tready`; the other source's tready = 0. On an accepted beat with tlast: RR pointer set to favour the other source, grant cleared, go to IDLE.
- XFER with `i_channel_up`=0:
  - If a tlast beat is accepted in that same cycle: the packet completes normally -> DOWN.
  - Otherwise -> FLUSH, grant held.
- FLUSH: m tvalid 0. Granted source tready = 1 and its beats are discarded. On granted tvalid & tlast: `o_drop_cnt` += 1 (saturating), grant cleared -> DOWN. Channel-up returning during FLUSH is ignored until DOWN.
- m data/keep/last = 0 whenever no grant or in FLUSH.
- A granted source never loses ownership mid-packet. Arbitration is never pre-empted.

## Timing
- Reset values: state DOWN, `o_grant`=00, RR pointer favours s0, counters 0, all treadys 0, `m_axi_tx_tvalid`=0, m data/keep/last 0, `o_link_ready`=0, `o_drop_cnt`=0.
- Treadys and m outputs are combinational from the registered state/grant and inputs. No data register, so zero-latency passthrough in XFER.
- IDLE->XFER costs one cycle: the first beat can be accepted in the cycle after the request is seen in IDLE.
- One IDLE bubble cycle between back-to-back packets.
- `i_channel_up` rise to first possible grant decision (IDLE): 1 + P_UP_WAIT cycles.
- Reset mid-packet: all state returns to reset values the next cycle. No drop is counted.

## Test plan
- Link bring-up: P_UP_WAIT=4, `i_channel_up` rises at cycle 10 -> `o_link_ready` high at cycle 15; s0 request held from cycle 0 -> first tvalid on m at cycle 16.
- Round-robin: both sources continuously send 3-beat packets, m tready=1 -> packets alternate s0,s1,s0,s1. Each packet is 3 beats followed by 1 idle cycle. `o_grant` sequence is 01,00,10,00,...
- Backpressure: m tready toggled 1,0,1,0 during a 4-beat s1 packet -> s1 tready mirrors m tready. Data is delivered in order with tkeep intact, including a final tkeep=4'b1100.
- Link loss mid-packet: `i_channel_up` drops after beat 2 of an 8-beat s0 packet -> m tvalid 0 from the next cycle; s0 drained with tready=1. `o_drop_cnt` becomes 1 on s0 tlast, then state DOWN.
- Link drop on tlast beat: `i_channel_up`=0 in the cycle the tlast beat is accepted -> packet completes, `o_drop_cnt` unchanged, state DOWN.
- Saturation/reset: force 65536 flushed packets -> `o_drop_cnt` holds 16'hFFFF; `i_rst` pulsed mid-XFER -> all outputs at reset values the next cycle.
